keypad_entry_ctrl: RTL and testbench
====================================

# keypad_entry_ctrl

Sequences keystrokes from `Keyboard_Scanner` into a validated two-digit decimal charge request for the charger control FSM. Consumes the scanner's `key_value`/`press` outputs, builds a BCD entry for the display, and range-checks it on confirm. It then holds the result with a valid/ack handshake until the downstream controller takes it. Sits between the keypad scanner and the charge/coin control logic on the 1 kHz system clock.

## Interface
Parameters:
- `MAX_VALUE`, 20: largest accepted entry (1..99).
- `TIMEOUT`, 10000: idle cycles in ENTRY before the entry is abandoned (10 s at 1 kHz); must be ≥2.
- `TW`, 14: width of the timeout counter; must hold `TIMEOUT-1`.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `en` in 1: key entry permitted.
- `key_value` in 4: scanner key code; qualified only when `press`=1.
- `press` in 1: one-cycle keystroke pulse from the scanner.
- `ack` in 1: downstream has consumed `value`.
- `value` out 7: accepted entry, binary; stable while `valid`=1.
- `valid` out 1: `value` available; held until ack.
- `digits` out 8: BCD display, `[7:4]` tens, `[3:0]` ones.
- `digit_cnt` out 2: digits currently entered (0..2).
- `error` out 1: one-cycle pulse on rejected confirm.
- `busy` out 1: state is ENTRY or DONE.

## Operation
- Key codes: 4'h0–4'h9 digit; 4'hA confirm; 4'hB cancel; 4'hC–4'hF ignored in all states.
- States: IDLE, ENTRY, DONE. Reset: IDLE, all outputs 0, timeout counter 0.
- IDLE: `digits`=0, `digit_cnt`=0.
  - Digit press with `en`=1: ones←key, `digit_cnt`=1, go to ENTRY.
  - Confirm or cancel: ignored.
- ENTRY, digit press:
  - `digit_cnt`<2: tens←ones, ones←key, `digit_cnt`+1.
  - `digit_cnt`=2: ignored.
  - Leading zero allowed: "0","5" = 5.
- ENTRY, confirm: compute v = tens·10 + ones (shift-add, 7 bits, max 99).
  - 1 ≤ v ≤ `MAX_VALUE`: `value`←v, `valid`=1, go to DONE. `digits` stay displayed.
  - Otherwise: `error` pulse, clear entry, go to IDLE.
- ENTRY, cancel: clear `digits`/`digit_cnt`, go to IDLE.
- ENTRY, `en`=0: clear, go to IDLE. Takes precedence over a same-cycle press.
- Timeout counter:
  - Cleared on entering ENTRY and on every accepted press; increments each ENTRY cycle with no press.
  - At `TIMEOUT-1` with no press that cycle: clear, go to IDLE, no `error`.
  - A press in the same cycle wins over the timeout.
- DONE: all presses and `en` ignored. `ack`=1 sampled: `valid`=0, `value`=0, clear `digits`/`digit_cnt`, go to IDLE.
- `ack` outside DONE: ignored.
- `busy` = (state≠IDLE).
- Reset mid-operation: immediate return to reset values; a pending `valid` is dropped.

## Timing
- All outputs registered.
- Press sampled at edge n → `digits`/`digit_cnt` updated after edge n.
- Confirm at edge n → `valid` or `error` after edge n. `error` lasts exactly one cycle.
- `ack` high at the first cycle `valid` is high is honoured: `valid` falls after that edge.
- Back-to-back presses on consecutive cycles are each processed.
- Timeout: IDLE reached exactly `TIMEOUT` cycles after the last accepted press.

## Configuration
- `KEYPAD_BACKSPACE_EN` defined: 4'hB in ENTRY is backspace.
  - `digit_cnt`=2: ones←tens, tens←0, `digit_cnt`=1, stay in ENTRY, timeout counter cleared.
  - `digit_cnt`=1: clear, go to IDLE.
- Undefined: 4'hB clears the whole entry (behaviour above).

## Test plan
- Keys 1, 5, A, ack held low 5 cycles then pulsed → `digits`=8'h15 after key 5; `valid`=1, `value`=15 after A; `valid` held 5 cycles; after ack `valid`=0, `digit_cnt`=0, `busy`=0.
- Keys 2, 5, A with `MAX_VALUE`=20 → one-cycle `error`, no `valid`, IDLE. Then keys 0, A → `error` (v=0).
- Keys 1, 2, 3 → third digit ignored, `digits`=8'h12. Press at cycle TIMEOUT-1 after key 2 keeps the entry alive. With no further press → IDLE `TIMEOUT` cycles after the last press, no `error`.
- Keys 1, 2, B → without macro: `digit_cnt`=0, IDLE. With `KEYPAD_BACKSPACE_EN`: `digits`=8'h01, `digit_cnt`=1; then 7, A → `value`=17.
- In DONE, keys and `en`=0 are ignored and `value` stays stable. In ENTRY, `en`=0 → IDLE. `rst_n` low while `valid`=1 → all outputs 0 immediately.

Source files
------------

// File: rtl/keypad_entry_ctrl_if.sv
// Keypad entry bus: scanner keystrokes and enable in, validated charge request with valid/ack out.
interface keypad_entry_ctrl_if;
    localparam int unsigned KEY_W = 4;
    localparam int unsigned VAL_W = 7;

    logic             en;
    logic [KEY_W-1:0] key_value;
    logic             press;
    logic             ack;
    logic [VAL_W-1:0] value;
    logic             valid;
    logic [7:0]       digits;
    logic [1:0]       digit_cnt;
    logic             error;
    logic             busy;

    modport master (
        output en, key_value, press, ack,
        input  value, valid, digits, digit_cnt, error, busy
    );

    modport slave (
        input  en, key_value, press, ack,
        output value, valid, digits, digit_cnt, error, busy
    );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Two-digit keypad entry sequencer with range check and valid/ack hand-off.
// Optional: define KEYPAD_BACKSPACE_EN to make key 4'hB a backspace in ENTRY.
module keypad_entry_ctrl #(
    parameter int unsigned MAX_VALUE = 20,
    parameter int unsigned TIMEOUT   = 10000,
    parameter int unsigned TW        = 14
) (
    input logic              clk,
    input logic              rst_n,
    keypad_entry_ctrl_if.slave kp
);
    localparam int unsigned VAL_W = 7;
    localparam int unsigned DIG_W = 4;

    typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [DIG_W-1:0]   tens_q, tens_d, ones_q, ones_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [VAL_W-1:0]   value_q, value_d;
    logic               valid_q, valid_d;
    logic               error_q, error_d;
    logic               busy_q, busy_d;
    logic [TW-1:0]      tmr_q, tmr_d;

    logic               key_digit, key_confirm, key_cancel, key_live;
    logic               tmo, in_range, bksp_stay;
    logic [VAL_W-1:0]   entry_v;

    assign key_digit   = kp.press && (kp.key_value <= 4'h9);
    assign key_confirm = kp.press && (kp.key_value == 4'hA);
    assign key_cancel  = kp.press && (kp.key_value == 4'hB);
    assign key_live    = key_digit || key_confirm || key_cancel;
    assign tmo         = (tmr_q == TW'(TIMEOUT - 1)) && !key_live;

    // tens*10 + ones as (tens<<3)+(tens<<1)+ones
    assign entry_v  = (VAL_W'(tens_q) << 3) + (VAL_W'(tens_q) << 1) + VAL_W'(ones_q);
    assign in_range = (entry_v != '0) && (entry_v <= VAL_W'(MAX_VALUE));

`ifdef KEYPAD_BACKSPACE_EN
    assign bksp_stay = key_cancel && (cnt_q == 2'd2);
`else
    assign bksp_stay = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tens_q  <= '0;
            ones_q  <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            valid_q <= valid_d;
            error_q <= error_d;
            busy_q  <= busy_d;
            tmr_q   <= tmr_d;
        end
    end

    // Loss of enable outranks any same-cycle key in ENTRY
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (kp.en && key_digit) state_d = S_ENTRY;
            S_ENTRY: begin
                if (!kp.en)                         state_d = S_IDLE;
                else if (key_confirm)               state_d = in_range ? S_DONE : S_IDLE;
                else if (key_cancel && !bksp_stay)  state_d = S_IDLE;
                else if (tmo)                       state_d = S_IDLE;
            end
            S_DONE:  if (kp.ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tens_d  = tens_q;
        ones_d  = ones_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        valid_d = valid_q;
        error_d = 1'b0;
        tmr_d   = tmr_q;
        busy_d  = (state_d != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                tmr_d = '0;
                if (kp.en && key_digit) begin
                    tens_d = '0;
                    ones_d = kp.key_value;
                    cnt_d  = 2'd1;
                end
            end
            S_ENTRY: begin
                if (state_d == S_IDLE) begin
                    tens_d  = '0;
                    ones_d  = '0;
                    cnt_d   = '0;
                    tmr_d   = '0;
                    error_d = kp.en && key_confirm;
                end else if (key_confirm) begin
                    value_d = entry_v;
                    valid_d = 1'b1;
                    tmr_d   = '0;
                end else begin
                    tmr_d = key_live ? '0 : tmr_q + TW'(1);
                    if (key_digit && (cnt_q != 2'd2)) begin
                        tens_d = ones_q;
                        ones_d = kp.key_value;
                        cnt_d  = cnt_q + 2'd1;
                    end
                    if (bksp_stay) begin
                        ones_d = tens_q;
                        tens_d = '0;
                        cnt_d  = 2'd1;
                    end
                end
            end
            S_DONE: begin
                if (kp.ack) begin
                    valid_d = 1'b0;
                    value_d = '0;
                    tens_d  = '0;
                    ones_d  = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                tens_d  = '0;
                ones_d  = '0;
                cnt_d   = '0;
                value_d = '0;
                valid_d = 1'b0;
                tmr_d   = '0;
            end
        endcase
    end

    assign kp.value     = value_q;
    assign kp.valid     = valid_q;
    assign kp.digits    = {tens_q, ones_q};
    assign kp.digit_cnt = cnt_q;
    assign kp.error     = error_q;
    assign kp.busy      = busy_q;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl with a short timeout so expiry is reachable.
module tb_keypad_entry_ctrl;
    localparam int unsigned MAXV = 20;
    localparam int unsigned TMO  = 8;
    localparam int unsigned TWID = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    keypad_entry_ctrl_if kp ();

    keypad_entry_ctrl #(.MAX_VALUE(MAXV), .TIMEOUT(TMO), .TW(TWID)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic vld, input logic [6:0] val,
                           input logic [7:0] dig, input logic [1:0] cnt,
                           input logic err, input logic bsy);
        chk({tag, ".valid"},     32'(kp.valid),     32'(vld));
        chk({tag, ".value"},     32'(kp.value),     32'(val));
        chk({tag, ".digits"},    32'(kp.digits),    32'(dig));
        chk({tag, ".digit_cnt"}, 32'(kp.digit_cnt), 32'(cnt));
        chk({tag, ".error"},     32'(kp.error),     32'(err));
        chk({tag, ".busy"},      32'(kp.busy),      32'(bsy));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] k);
        kp.key_value = k;
        kp.press     = 1'b1;
        tick();
        kp.press     = 1'b0;
        kp.key_value = 4'h0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_ack();
        kp.ack = 1'b1;
        tick();
        kp.ack = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        kp.en        = 1'b0;
        kp.key_value = 4'h0;
        kp.press     = 1'b0;
        kp.ack       = 1'b0;
        idle(2);
        chk_all("reset", 0, 0, 8'h00, 0, 0, 0);
        rst_n = 1'b1;
        kp.en = 1'b1;
        idle(1);

        // Basic 1,5,confirm with delayed ack
        key(4'h1);  chk_all("k1", 0, 0, 8'h01, 1, 0, 1);
        key(4'h5);  chk_all("k15", 0, 0, 8'h15, 2, 0, 1);
        key(4'hA);  chk_all("conf15", 1, 15, 8'h15, 2, 0, 1);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("hold15.valid", 32'(kp.valid), 32'd1);
            chk("hold15.value", 32'(kp.value), 32'd15);
        end
        do_ack();   chk_all("ack15", 0, 0, 8'h00, 0, 0, 0);

        // Above MAX_VALUE -> one-cycle error
        key(4'h2); key(4'h5); key(4'hA);
        chk_all("err25", 0, 0, 8'h00, 0, 1, 0);
        idle(1);    chk("err25.pulse_end", 32'(kp.error), 32'd0);

        // Zero entry rejected
        key(4'h0); key(4'hA);
        chk_all("err0", 0, 0, 8'h00, 0, 1, 0);
        idle(1);    chk("err0.pulse_end", 32'(kp.error), 32'd0);

        // Exactly MAX_VALUE accepted, ack on the first valid cycle
        key(4'h2); key(4'h0); key(4'hA);
        chk_all("conf20", 1, 20, 8'h20, 2, 0, 1);
        do_ack();   chk_all("ack20", 0, 0, 8'h00, 0, 0, 0);

        // Leading zero
        key(4'h0); key(4'h5); key(4'hA);
        chk_all("conf05", 1, 5, 8'h05, 2, 0, 1);
        do_ack();

        // Third digit ignored; a press on the expiry edge keeps the entry alive
        key(4'h1); key(4'h2);
        idle(TMO - 1);
        chk_all("tmo_pre", 0, 0, 8'h12, 2, 0, 1);
        key(4'h3);  chk_all("tmo_save", 0, 0, 8'h12, 2, 0, 1);
        idle(TMO - 1);
        chk_all("tmo_edge", 0, 0, 8'h12, 2, 0, 1);
        idle(1);    chk_all("tmo_fire", 0, 0, 8'h00, 0, 0, 0);

        // Cancel / backspace
        key(4'h1); key(4'h2); key(4'hB);
`ifdef KEYPAD_BACKSPACE_EN
        chk_all("bksp", 0, 0, 8'h01, 1, 0, 1);
        key(4'h7); key(4'hA);
        chk_all("bksp_conf", 1, 17, 8'h17, 2, 0, 1);
        do_ack();
`else
        chk_all("cancel", 0, 0, 8'h00, 0, 0, 0);
`endif

        // DONE ignores keys and en
        key(4'h1); key(4'h8); key(4'hA);
        chk_all("conf18", 1, 18, 8'h18, 2, 0, 1);
        key(4'h9);  chk_all("done_key", 1, 18, 8'h18, 2, 0, 1);
        kp.en = 1'b0;
        idle(1);    chk_all("done_en0", 1, 18, 8'h18, 2, 0, 1);
        key(4'hB);  chk_all("done_cancel", 1, 18, 8'h18, 2, 0, 1);
        kp.en = 1'b1;
        do_ack();   chk_all("ack18", 0, 0, 8'h00, 0, 0, 0);

        // en drop in ENTRY beats a same-cycle digit
        key(4'h4);
        kp.en = 1'b0;
        key(4'h5);  chk_all("entry_en0", 0, 0, 8'h00, 0, 0, 0);
        // IDLE: digit with en=0, confirm, and stray ack are ignored
        key(4'h3);  chk_all("idle_en0", 0, 0, 8'h00, 0, 0, 0);
        kp.en = 1'b1;
        key(4'hA);  chk_all("idle_conf", 0, 0, 8'h00, 0, 0, 0);
        do_ack();   chk_all("idle_ack", 0, 0, 8'h00, 0, 0, 0);

        // Codes C..F ignored in ENTRY
        key(4'h1); key(4'hC);
        chk_all("key_c", 0, 0, 8'h01, 1, 0, 1);
        key(4'hB);  chk_all("clr1", 0, 0, 8'h00, 0, 0, 0);

        // Reset while valid is pending
        key(4'h1); key(4'h9); key(4'hA);
        chk_all("conf19", 1, 19, 8'h19, 2, 0, 1);
        rst_n = 1'b0;
        #1;
        chk_all("rst_mid", 0, 0, 8'h00, 0, 0, 0);
        idle(1);
        rst_n = 1'b1;
        idle(1);
        chk_all("post_rst", 0, 0, 8'h00, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
